spi_txn_arbiter: RTL
====================

// Module: spi_txn_arbiter
// PURPOSE
//  Shares one byte-level SPI engine (txdin/txgo/txrdy/rxdout/rxnew handshake) among NREQ requesters.
//  Grants round-robin, owns per-requester slave selects, and sequences a whole multi-byte transaction:
//  CS setup, byte issue, RX capture, CS hold.
//  Sits between AHB peripheral front-ends (or DMA-style clients) and the shared SPI engine.
// PARAMETERS
//  NREQ      2   number of requesters (2..4)
//  LW        4   width of byte-count field; max transaction 2^LW-1 bytes
//  CS_SETUP  2   HCLK cycles ss_n low before first byte issued (>=1)
//  CS_HOLD   2   HCLK cycles ss_n held low after last rxnew (>=1)
//  TIMEOUT   1023  max HCLK cycles in WAIT without rxnew before abort
// PORTS
//  HCLK        in   1        clock
//  HRESETn     in   1        reset, asynchronous, active-low
//  req         in   NREQ     level request per requester, held until done/err
//  req_len     in   NREQ*LW  byte count per requester, slice i = [i*LW +: LW]
//  req_wdata   in   NREQ*8   current TX byte per requester, slice i = [i*8 +: 8]
//  req_wnext   out  NREQ     1-cycle pulse: granted requester's TX byte consumed, present next byte
//  rdata       out  8        last received byte
//  rvalid      out  NREQ     1-cycle pulse to granted requester: rdata valid
//  done        out  NREQ     1-cycle pulse: transaction complete
//  err         out  NREQ     1-cycle pulse: transaction aborted on timeout
//  grant       out  NREQ     one-hot current owner, 0 when idle
//  ss_n        out  NREQ     active-low slave selects, at most one low
//  eng_txdin   out  8        byte to engine
//  eng_txgo    out  1        byte available to engine
//  eng_txrdy   in   1        engine ready; byte accepted on edge where txgo&txrdy
//  eng_rxdout  in   8        received byte from engine
//  eng_rxnew   in   1        1-cycle strobe, eng_rxdout valid
// BEHAVIOUR
//  Reset:
//   - All outputs 0 except ss_n = all 1; state IDLE.
//   - Round-robin pointer = requester 0 highest priority.
//   - Reset mid-transaction drops ss_n immediately (async); no done/err.
//  FSM: IDLE -> SETUP -> SEND <-> WAIT -> HOLD -> IDLE.
//   IDLE:
//    - If any req: pick first set bit at or after ptr (wrapping); register grant, latch cnt=req_len.
//    - Set ptr = winner+1 mod NREQ.
//    - If latched len==0: pulse done next cycle, no ss_n, return IDLE.
//    - Else -> SETUP with ss_n[winner]=0 from the same edge grant rises.
//   SETUP: count CS_SETUP cycles, then -> SEND.
//   SEND:
//    - eng_txgo=1, eng_txdin=req_wdata slice of grant.
//    - On edge with eng_txrdy=1: req_wnext[g] pulses (combinational txgo&txrdy), -> WAIT, timer cleared.
//   WAIT:
//    - On eng_rxnew: rdata<=eng_rxdout, rvalid[g] pulses next cycle, cnt<=cnt-1.
//    - cnt==1 before decrement -> HOLD, else -> SEND.
//    - eng_txgo=0 in WAIT.
//    - Timer reaching TIMEOUT -> err[g] pulse, ss_n all 1, grant 0, -> IDLE (no HOLD).
//   HOLD: count CS_HOLD cycles; on exit: done[g] pulses, grant<=0, ss_n all 1, -> IDLE.
//  Gaps and latency:
//   - IDLE lasts >=1 cycle: ss_n high >=1 cycle between transactions.
//   - Minimum grant latency: req high -> grant/ss_n low 1 cycle later.
//  Boundary conditions:
//   - req deassert while granted: ignored; transaction runs to completion on latched count.
//   - req_len changes after grant: ignored.
//   - eng_rxnew outside WAIT: ignored (no rvalid).
//   - rxnew and timeout on same cycle: rxnew wins.
//   - All requesters active continuously: strict rotation 0,1,..,NREQ-1,0; no starvation.
//  Assertion invariants: grant and ~ss_n each one-hot or zero; ~ss_n equals grant except IDLE/len0.
// TESTING
//  - Single req[0], len=3, bytes A1,B2,C3, engine echoes +1 ->
//    3 wnext, rvalid with A2,B3,C4, done[0], ss_n[0] low CS_SETUP+xfer+CS_HOLD.
//  - req=4'b1111 held, len=1 each -> grants 0,1,2,3,0 in order, ss_n high >=1 cycle between.
//  - len=0 on req[1] -> done[1] pulse 2 cycles after req, ss_n never low, no wnext.
//  - Engine never strobes rxnew after first byte ->
//    err[0] after TIMEOUT cycles in WAIT, ss_n all 1, next requester granted.
//  - req[0] dropped after first byte of len=4 -> all 4 bytes still transferred, done[0].
//  - HRESETn low mid-WAIT -> ss_n=all 1, grant=0, txgo=0 immediately; after release, new req serviced from ptr=0.

Source files
------------

// File: rtl/spi_txn_arbiter_if.sv
// Requester-side and SPI-engine-side handshake bundle for spi_txn_arbiter.
interface spi_txn_arbiter_if #(
  parameter int NREQ = 2,
  parameter int LW   = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*LW-1:0] req_len;
  logic [NREQ*8-1:0]  req_wdata;
  logic [NREQ-1:0]    req_wnext;
  logic [7:0]         rdata;
  logic [NREQ-1:0]    rvalid;
  logic [NREQ-1:0]    done;
  logic [NREQ-1:0]    err;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    ss_n;
  logic [7:0]         eng_txdin;
  logic               eng_txgo;
  logic               eng_txrdy;
  logic [7:0]         eng_rxdout;
  logic               eng_rxnew;

  modport slave (
    input  req, req_len, req_wdata, eng_txrdy, eng_rxdout, eng_rxnew,
    output req_wnext, rdata, rvalid, done, err, grant, ss_n, eng_txdin, eng_txgo
  );

  modport master (
    output req, req_len, req_wdata, eng_txrdy, eng_rxdout, eng_rxnew,
    input  req_wnext, rdata, rvalid, done, err, grant, ss_n, eng_txdin, eng_txgo
  );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one byte-level SPI engine among NREQ requesters;
// sequences CS setup, byte issue, RX capture and CS hold for each transaction.
module spi_txn_arbiter #(
  parameter int NREQ     = 2,
  parameter int LW       = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int TIMEOUT  = 1023
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  spi_txn_arbiter_if.slave  bus
);
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAXA = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int MAXC = (TIMEOUT > MAXA) ? TIMEOUT : MAXA;
  localparam int TW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SEND, WAIT, HOLD} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] ss_n_q, ss_n_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] err_q, err_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [7:0]      rdata_q, rdata_d;

  logic            found;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   win;
  logic [NREQ-1:0] win_oh;
  logic [LW-1:0]   len_win;
  logic [7:0]      wdata_own;
  logic            txgo;

  // Search order starts at ptr and wraps, so the last winner drops to lowest priority.
  always_comb begin
    found     = 1'b0;
    idx       = '0;
    win       = '0;
    len_win   = '0;
    wdata_own = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IW'((32'(ptr_q) + k) % 32'(NREQ));
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (win == IW'(k))     len_win   = bus.req_len[k*LW +: LW];
      if (owner_q == IW'(k)) wdata_own = bus.req_wdata[k*8 +: 8];
    end
    win_oh = NREQ'(1) << win;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ss_n_d   = ss_n_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    rdata_d  = rdata_q;
    rvalid_d = '0;
    done_d   = '0;
    err_d    = '0;
    txgo     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A grant still held in IDLE is a zero-length transaction retiring without ss_n.
        if (grant_q != '0) begin
          done_d  = grant_q;
          grant_d = '0;
        end else if (found) begin
          grant_d = win_oh;
          owner_d = win;
          cnt_d   = len_win;
          ptr_d   = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
          tmr_d   = '0;
          if (len_win != '0) begin
            ss_n_d  = ~win_oh;
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        if (tmr_q == TW'(CS_SETUP - 1)) state_d = SEND;
        else                            tmr_d   = tmr_q + 1'b1;
      end
      SEND: begin
        txgo = 1'b1;
        if (bus.eng_txrdy) begin
          state_d = WAIT;
          tmr_d   = '0;
        end
      end
      WAIT: begin
        if (bus.eng_rxnew) begin
          rdata_d  = bus.eng_rxdout;
          rvalid_d = grant_q;
          cnt_d    = cnt_q - 1'b1;
          tmr_d    = '0;
          state_d  = (cnt_q == LW'(1)) ? HOLD : SEND;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          err_d   = grant_q;
          grant_d = '0;
          ss_n_d  = '1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      HOLD: begin
        if (tmr_q == TW'(CS_HOLD - 1)) begin
          done_d  = grant_q;
          grant_d = '0;
          ss_n_d  = '1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ss_n_q   <= '1;
      rvalid_q <= '0;
      done_q   <= '0;
      err_q    <= '0;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      tmr_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ss_n_q   <= ss_n_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.eng_txgo  = txgo;
  assign bus.eng_txdin = txgo ? wdata_own : '0;
  assign bus.req_wnext = grant_q & {NREQ{txgo & bus.eng_txrdy}};
  assign bus.rdata     = rdata_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.grant     = grant_q;
  assign bus.ss_n      = ss_n_q;

  a_grant_onehot: assert property (@(posedge HCLK) disable iff (!HRESETn) $onehot0(grant_q));
  a_ss_onehot:    assert property (@(posedge HCLK) disable iff (!HRESETn) $onehot0(~ss_n_q));
  a_ss_is_grant:  assert property (@(posedge HCLK) disable iff (!HRESETn)
                                   (state_q != IDLE) |-> (~ss_n_q == grant_q));
endmodule
